// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared op encodings and default width for the stack pointer
package sp_pkg;

    localparam int SP_BITS = 8;

    typedef enum logic {
        SP_OP_DEC = 1'b0,
        SP_OP_INC = 1'b1
    } sp_op_e;

endpackage

// File: rtl/stack_pointer_if.sv
// rtl/stack_pointer_if.sv - stack pointer step/value bundle; full/empty exist only with SP_FLAGS_EN
interface stack_pointer_if #(
    parameter int BITS = 8
);

    logic            write_enable;
    logic            op;
    logic [BITS-1:0] sp;
`ifdef SP_FLAGS_EN
    logic            full;
    logic            empty;
`endif

`ifdef SP_FLAGS_EN
    modport master (
        output write_enable,
        output op,
        input  sp,
        input  full,
        input  empty
    );

    modport slave (
        input  write_enable,
        input  op,
        output sp,
        output full,
        output empty
    );
`else
    modport master (
        output write_enable,
        output op,
        input  sp
    );

    modport slave (
        input  write_enable,
        input  op,
        output sp
    );
`endif

endinterface

// File: rtl/sp_step.sv
// rtl/sp_step.sv - combinational saturating +/-1 of the pointer value
module sp_step
    import sp_pkg::*;
#(
    parameter int BITS = SP_BITS
) (
    input  logic [BITS-1:0] i_value,
    input  logic            i_op,
    output logic [BITS-1:0] o_next
);

    logic w_at_max;
    logic w_at_min;

    assign w_at_max = (i_value == {BITS{1'b1}});
    assign w_at_min = (i_value == {BITS{1'b0}});

    // Saturate at either end instead of wrapping.
    always_comb begin
        o_next = i_value;
        if (i_op == SP_OP_INC) begin
            if (!w_at_max) begin
                o_next = i_value + BITS'(1);
            end
        end else begin
            if (!w_at_min) begin
                o_next = i_value - BITS'(1);
            end
        end
    end

endmodule

// File: rtl/stack_pointer.sv
// rtl/stack_pointer.sv - saturating up/down stack pointer register; SP_FLAGS_EN adds full/empty
module stack_pointer
    import sp_pkg::*;
#(
    parameter int BITS = SP_BITS
) (
    input  logic clk,
    input  logic rst_n,
    stack_pointer_if.slave bus
);

    logic [BITS-1:0] r_sp;
    logic [BITS-1:0] w_next;

    sp_step #(
        .BITS (BITS)
    ) u_step (
        .i_value (r_sp),
        .i_op    (bus.op),
        .o_next  (w_next)
    );

    // Reset wins over a concurrent step request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (bus.write_enable) begin
            r_sp <= w_next;
        end
    end

    assign bus.sp = r_sp;

`ifdef SP_FLAGS_EN
    assign bus.full  = (r_sp == {BITS{1'b1}});
    assign bus.empty = (r_sp == {BITS{1'b0}});
`endif

endmodule

// File: tb/tb_stack_pointer.sv
// tb/tb_stack_pointer.sv - directed self-checking bench for stack_pointer (BITS = 8)
module tb_stack_pointer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_sp;

    stack_pointer_if #(.BITS(8)) bus ();

    stack_pointer #(
        .BITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_flags(input string tag);
`ifdef SP_FLAGS_EN
        check({tag, "_full"},  {31'd0, bus.full},  {31'd0, exp_sp == 8'hFF});
        check({tag, "_empty"}, {31'd0, bus.empty}, {31'd0, exp_sp == 8'h00});
`else
        check({tag, "_sp"}, {24'd0, bus.sp}, {24'd0, exp_sp});
`endif
    endtask

    // One edge with given controls; reference model advances alongside.
    task automatic do_step(input logic rst_val, input logic we, input logic op, input string tag);
        rst_n            = rst_val;
        bus.write_enable = we;
        bus.op           = op;
        @(posedge clk);
        if (!rst_val) begin
            exp_sp = 8'h00;
        end else if (we) begin
            if (op && exp_sp != 8'hFF) exp_sp = exp_sp + 8'd1;
            else if (!op && exp_sp != 8'h00) exp_sp = exp_sp - 8'd1;
        end
        #1;
        check(tag, {24'd0, bus.sp}, {24'd0, exp_sp});
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        exp_sp           = 8'h00;
        rst_n            = 1'b0;
        bus.write_enable = 1'b0;
        bus.op           = 1'b0;

        do_step(1'b0, 1'b0, 1'b0, "reset0");
        do_step(1'b0, 1'b1, 1'b1, "reset1");
        check("reset_const", {24'd0, bus.sp}, 32'h0);
        check_flags("reset");

        for (int i = 0; i < 5; i++) begin
            do_step(1'b1, 1'b0, i[0], "gate");
        end
        check("gate_const", {24'd0, bus.sp}, 32'h0);

        for (int i = 0; i < 255; i++) begin
            do_step(1'b1, 1'b1, 1'b1, "up");
        end
        check("up_top", {24'd0, bus.sp}, 32'hFF);
        do_step(1'b1, 1'b1, 1'b1, "up_sat");
        check("up_sat_const", {24'd0, bus.sp}, 32'hFF);
        check_flags("at_top");

        for (int i = 0; i < 255; i++) begin
            do_step(1'b1, 1'b1, 1'b0, "down");
        end
        check("down_bot", {24'd0, bus.sp}, 32'h0);
        do_step(1'b1, 1'b1, 1'b0, "down_sat");
        check("down_sat_const", {24'd0, bus.sp}, 32'h0);
        check_flags("at_bot");

        for (int i = 0; i < 10; i++) begin
            do_step(1'b1, ~i[0], 1'b1, "alt");
        end
        check("alt_const", {24'd0, bus.sp}, 32'h05);

        for (int i = 0; i < 59; i++) begin
            do_step(1'b1, 1'b1, 1'b1, "climb");
        end
        check("climb_const", {24'd0, bus.sp}, 32'h40);
        check_flags("mid");
        do_step(1'b0, 1'b1, 1'b1, "mid_reset");
        check("mid_reset_const", {24'd0, bus.sp}, 32'h0);
        check_flags("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_pointer.md
# stack_pointer

Saturating up/down stack pointer register for the CPU datapath. It holds the current stack address and steps it by one per enabled clock: up when `op` is 1, down when `op` is 0. It sits beside the register file and feeds the memory address mux for stack accesses.

## Interface
- `BITS`, default 8: width of the pointer.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `write_enable`  input  1  when 1, the pointer steps on this rising edge.
- `op`  input  1  step direction: 1 = increment, 0 = decrement.
- `sp`  output  BITS  current pointer value, driven directly from the register.

## Operation
- The pointer is a single BITS-wide register; `sp` is that register with no added logic.
- Priority at each rising edge of `clk`:
  - `rst_n` = 0: register ← 0.
  - else `write_enable` = 1, `op` = 1: register ← register + 1, except it holds at 2^BITS−1 when already at 2^BITS−1.
  - else `write_enable` = 1, `op` = 0: register ← register − 1, except it holds at 0 when already at 0.
  - else: register holds.
- Saturation replaces wrap-around in both directions.
- Arithmetic is unsigned at BITS width; no carry or borrow leaves the block.
- `op` is ignored while `write_enable` = 0.

## Timing
- Reset value of `sp`: 0, visible after the first rising edge with `rst_n` low.
- Latency: one cycle. A step requested at edge N is visible on `sp` immediately after edge N.
- No handshake. A step is accepted on every enabled edge, so back-to-back steps are legal.
- Reset asserted while `write_enable` = 1 wins: the pointer goes to 0 and the step is discarded.
- Inputs must be stable around the rising edge. `sp` is glitch-free between edges.

## Configuration
- Macro `SP_FLAGS_EN`:
  - Defined: adds two outputs, both 1 bit and combinational from the register.
    - `full` is 1 when `sp` = 2^BITS−1.
    - `empty` is 1 when `sp` = 0.
    - After reset: `full` = 0, `empty` = 1.
  - Undefined: these ports do not exist. Pointer behaviour is identical in both cases.

## Structure
- Shared package `sp_pkg` holds:
  - op encodings: `SP_OP_INC` = 1'b1, `SP_OP_DEC` = 1'b0.
  - default width constant `SP_BITS` = 8.
- One sub-module, `sp_step`. It is purely combinational and BITS-parameterised:
  - inputs: current value, `op`.
  - output: the saturated next value.
- The top level is only the register, the reset/enable mux, and the optional flags.

## Test plan
Use BITS = 8 throughout.
- Reset: hold `rst_n` = 0 for 2 edges → `sp` = 0x00. With `SP_FLAGS_EN`: `empty` = 1, `full` = 0.
- Enable gating: `write_enable` = 0 with `op` toggling for 5 edges → `sp` stays 0x00.
- Count up: from 0x00, 255 enabled edges with `op` = 1 → `sp` goes 0x01, 0x02, … 0xFF. One more enabled edge → `sp` stays 0xFF (`full` = 1).
- Count down: from 0xFF, 255 enabled edges with `op` = 0 → `sp` reaches 0x00. One more enabled edge → `sp` stays 0x00 (`empty` = 1).
- Alternating steps: `write_enable` toggles every edge with `op` = 1 from 0x00 for 10 edges → `sp` = 0x05, changing only on enabled edges.
- Reset mid-run: at `sp` = 0x40, assert `rst_n` = 0 together with `write_enable` = 1, `op` = 1 → `sp` = 0x00 after that edge.
